// File: rtl/ws2812_stream_tx_if.sv
// Pixel-word handshake between the pixel-buffer reader and the WS2812 serialiser.
// The master presents a word with its end-of-frame flag; the slave accepts it when ready.
interface ws2812_stream_tx_if #(
  parameter int BITS_PER_PIXEL = 24
) ();
  logic [BITS_PER_PIXEL-1:0] pixel_data;
  logic                      pixel_last;
  logic                      pixel_valid;
  logic                      pixel_ready;

  modport master (
    output pixel_data,
    output pixel_last,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_last,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/ws2812_stream_tx.sv
// WS2812 serialiser: shifts pixel words out MSB first with clock-derived bit timing,
// a one-word holding register for gap-free streaming, a frame latch period and underrun flag.
module ws2812_stream_tx #(
  parameter int CLK_HZ         = 12_000_000,
  parameter int BITS_PER_PIXEL = 24,
  parameter int T0H_NS         = 350,
  parameter int T1H_NS         = 700,
  parameter int TBIT_NS        = 1250,
  parameter int TLATCH_US      = 80
) (
  input  logic                clk,
  input  logic                rst_n,
  ws2812_stream_tx_if.slave   pix,
  output logic                d_out,
  output logic                busy,
  output logic                underrun,
  output logic [15:0]         pixel_count
);

  function automatic int to_cycles(input longint t, input longint per_sec);
    longint c;
    c = (longint'(CLK_HZ) * t) / per_sec;
    return (c < 64'sd1) ? 1 : int'(c);
  endfunction

  localparam int T0H_CYC    = to_cycles(longint'(T0H_NS), 64'sd1_000_000_000);
  localparam int T1H_CYC    = to_cycles(longint'(T1H_NS), 64'sd1_000_000_000);
  localparam int TBIT_CYC   = to_cycles(longint'(TBIT_NS), 64'sd1_000_000_000);
  localparam int TLATCH_CYC = to_cycles(longint'(TLATCH_US), 64'sd1_000_000);

  localparam int CNT_TOP_A = (TBIT_CYC > TLATCH_CYC) ? TBIT_CYC : TLATCH_CYC;
  localparam int CNT_TOP   = (T1H_CYC > CNT_TOP_A) ? T1H_CYC : CNT_TOP_A;
  localparam int CNT_W     = $clog2(CNT_TOP + 1);
  localparam int BIT_W     = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [CNT_W-1:0] T0H_LAST    = CNT_W'(T0H_CYC - 1);
  localparam logic [CNT_W-1:0] T1H_LAST    = CNT_W'(T1H_CYC - 1);
  localparam logic [CNT_W-1:0] TBIT_LAST   = CNT_W'(TBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TLATCH_LAST = CNT_W'(TLATCH_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST   = BIT_W'(BITS_PER_PIXEL - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIGH  = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [1:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [BITS_PER_PIXEL-1:0] hold_data;
  logic                      hold_last;
  logic                      hold_full;
  logic                      cur_last;

  logic                      accept;
  logic                      bit_end;
  logic                      pixel_end;
  logic                      unload;
  logic                      next_bit;
  logic [CNT_W-1:0]          high_last;

  assign pix.pixel_ready = ~hold_full;
  assign busy            = (state != S_IDLE) || hold_full;
  assign accept          = pix.pixel_valid && ~hold_full;

  // The counter keeps running from HIGH into LOW so the whole bit lasts exactly TBIT cycles.
  assign high_last = shreg[BITS_PER_PIXEL-1] ? T1H_LAST : T0H_LAST;
  assign bit_end   = (state == S_LOW) && (cnt >= TBIT_LAST);
  assign pixel_end = bit_end && (bit_cnt == '0);
  assign next_bit  = bit_end && (bit_cnt != '0);
  assign unload    = hold_full &&
                     ((state == S_IDLE) || (pixel_end && !cur_last));

  // NOTE: datapath registers carry no reset; hold_full and state qualify every use of them.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= pix.pixel_data;
      hold_last <= pix.pixel_last;
    end
    if (unload) begin
      shreg <= hold_data;
    end else if (next_bit) begin
      shreg <= shreg << 1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      cur_last    <= 1'b0;
      hold_full   <= 1'b0;
      d_out       <= 1'b0;
      underrun    <= 1'b0;
      pixel_count <= '0;
    end else begin
      underrun <= 1'b0;

      // Unload only happens while full and accept only while empty, so they never collide.
      if (unload) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end

      if (unload) begin
        state    <= S_HIGH;
        d_out    <= 1'b1;
        cnt      <= '0;
        bit_cnt  <= BIT_FIRST;
        cur_last <= hold_last;
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
        end

        S_HIGH: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt >= high_last) begin
            d_out <= 1'b0;
            state <= S_LOW;
          end
        end

        S_LOW: begin
          if (next_bit) begin
            bit_cnt <= bit_cnt - BIT_W'(1);
            d_out   <= 1'b1;
            cnt     <= '0;
            state   <= S_HIGH;
          end else if (pixel_end) begin
            pixel_count <= pixel_count + 16'd1;
            if (cur_last) begin
              cnt   <= '0;
              state <= S_LATCH;
            end else if (!hold_full) begin
              cnt      <= '0;
              state    <= S_IDLE;
              underrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_LATCH: begin
          // A word may already sit in hold here; it waits for IDLE before transmitting.
          if (cnt >= TLATCH_LAST) begin
            cnt         <= '0;
            pixel_count <= '0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          d_out <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
